// File: rtl/imem_loader_if.sv
// Debug-side control plus instruction-memory write-port bundle for imem_loader.
// The master drives start and UART bytes; the slave (the loader) drives memory writes and status.
interface imem_loader_if #(
  parameter int MEMORY_WIDTH = 8,
  parameter int NB_ADDR      = 32
);
  logic                    i_start;
  logic [MEMORY_WIDTH-1:0] i_rx_data;
  logic                    i_rx_done;
  logic                    o_write_enable;
  logic [MEMORY_WIDTH-1:0] o_write_data;
  logic [NB_ADDR-1:0]      o_write_addr;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_error;
  logic [NB_ADDR-1:0]      o_byte_count;

  modport master (
    output i_start, i_rx_data, i_rx_done,
    input  o_write_enable, o_write_data, o_write_addr,
    input  o_busy, o_done, o_error, o_byte_count
  );

  modport slave (
    input  i_start, i_rx_data, i_rx_done,
    output o_write_enable, o_write_data, o_write_addr,
    output o_busy, o_done, o_error, o_byte_count
  );
endinterface

// File: rtl/imem_loader.sv
// Streams UART bytes into instruction memory from address 0; stops on an aligned HALT word or overflow.
// One byte per cycle; write strobe one edge after rx_done; status flags trail the state by one edge.
module imem_loader #(
  parameter int          MEMORY_WIDTH = 8,
  parameter int          MEMORY_DEPTH = 256,
  parameter int          NB_ADDR      = 32,
  parameter logic [31:0] HALT_WORD    = 32'hFFFFFFFF
) (
  input  logic          i_clock,
  input  logic          i_reset,
  imem_loader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  localparam logic [NB_ADDR-1:0] DEPTH = NB_ADDR'(MEMORY_DEPTH);

  state_t                  state_q, state_d;
  logic [NB_ADDR-1:0]      addr_q, addr_d;
  logic [NB_ADDR-1:0]      count_q, count_d;
  logic [31:0]             shift_q, shift_d;
  logic [31:0]             word_in;
  logic                    we_q, we_d;
  logic [MEMORY_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB_ADDR-1:0]      waddr_q, waddr_d;
  logic                    busy_q, done_q, error_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      shift_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      shift_q <= shift_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      // Flags decode the previous state so DONE is only reported after the final write commits.
      busy_q  <= (state_q == LOAD);
      done_q  <= (state_q == DONE);
      error_q <= (state_q == ERROR);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    shift_d = shift_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    word_in = {shift_q[31-MEMORY_WIDTH:0], bus.i_rx_data};

    if (bus.i_start) begin
      // Start has priority over a coincident byte, which is dropped.
      state_d = LOAD;
      addr_d  = '0;
      count_d = '0;
      shift_d = '0;
    end else if (state_q == LOAD && bus.i_rx_done) begin
      if (addr_q < DEPTH) begin
        we_d    = 1'b1;
        wdata_d = bus.i_rx_data;
        waddr_d = addr_q;
        shift_d = word_in;
        addr_d  = addr_q + NB_ADDR'(1);
        count_d = count_q + NB_ADDR'(1);
        if (addr_q[1:0] == 2'b11 && word_in == HALT_WORD) begin
          state_d = DONE;
        end
      end else begin
        state_d = ERROR;
      end
    end
  end

  assign bus.o_write_enable = we_q;
  assign bus.o_write_data   = wdata_q;
  assign bus.o_write_addr   = waddr_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
  assign bus.o_error        = error_q;
  assign bus.o_byte_count   = count_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader that sits directly upstream of the instruction memory's debug write port. It accepts program bytes from the UART receiver and writes them into instruction memory at consecutive byte addresses starting at 0. Loading stops on a word-aligned HALT word or on memory overflow. The debug unit arms it with `i_start` and watches `o_done`/`o_error` to know when the pipeline may run.

## Interface
- `MEMORY_WIDTH`, 8: byte width; matches instruction memory data width.
- `MEMORY_DEPTH`, 256: instruction memory depth in bytes; overflow bound.
- `NB_ADDR`, 32: write address and byte-count width.
- `HALT_WORD`, 32'hFFFFFFFF: 32-bit terminator instruction.

- `i_clock`, input, 1: single clock, rising edge.
- `i_reset`, input, 1: synchronous, active-low reset.
- `i_start`, input, 1: one-cycle pulse; arms or restarts a load.
- `i_rx_data`, input, MEMORY_WIDTH: received byte; valid only with `i_rx_done`.
- `i_rx_done`, input, 1: one-cycle strobe from the UART receiver.
- `o_write_enable`, output, 1: drives the memory `i_write_enable`; one-cycle pulse per byte.
- `o_write_data`, output, MEMORY_WIDTH: drives the memory `i_write_data`.
- `o_write_addr`, output, NB_ADDR: drives the memory `i_write_addr`.
- `o_busy`, output, 1: high while in LOAD.
- `o_done`, output, 1: level; load ended on HALT.
- `o_error`, output, 1: level; load ended on overflow.
- `o_byte_count`, output, NB_ADDR: bytes written in the current or last load.

## Operation
- States: IDLE, LOAD, DONE, ERROR. All outputs are registered.
- Reset (`i_reset`=0 at a rising edge), from any state:
  - State goes to IDLE.
  - All outputs go to 0; the address counter, byte count and word shift register clear.
- IDLE: `i_rx_done` is ignored. `i_start` moves to LOAD and clears the address, count and shift register.
- LOAD, on each `i_rx_done` when address < MEMORY_DEPTH:
  - Issue a write of `i_rx_data` to the current address.
  - Shift the byte into a 32-bit register, big-endian: first byte of a word lands in [31:24]. This matches memory read order.
  - Increment the address and `o_byte_count`.
- HALT detection: only on the 4th byte of an aligned word (address[1:0]==3 at acceptance).
  - If the assembled word equals HALT_WORD, the byte is still written and the state goes to DONE.
  - An unaligned FF FF FF FF sequence does not terminate the load.
- Overflow: `i_rx_done` in LOAD with address == MEMORY_DEPTH means:
  - No write is issued.
  - State goes to ERROR; count is unchanged.
- DONE and ERROR: `i_rx_done` is ignored. The `o_done`/`o_error` level holds until `i_start` or reset. `i_start` re-arms (same as from IDLE) and clears the flags.
- `i_start` in LOAD restarts at address 0.
- A simultaneous `i_start` and `i_rx_done`, in any state: start wins and the byte is dropped.
- Address arithmetic is unsigned NB_ADDR bits with no wrap. The count never exceeds MEMORY_DEPTH.

## Timing
- `i_rx_done` sampled high at edge k:
  - `o_write_enable`=1, `o_write_data`, `o_write_addr` valid during cycle k..k+1.
  - The memory captures the byte at edge k+1.
- `o_write_enable` is never high two consecutive cycles unless `i_rx_done` was.
- Back-to-back `i_rx_done` (every cycle) is supported at one byte per cycle.
- `o_byte_count` updates at edge k, the same edge as the write strobe rises.
- HALT byte accepted at edge k:
  - Write strobe is high cycle k..k+1.
  - `o_busy` falls at edge k+1; `o_done` rises at edge k+1. This is after the final write commits.
- Overflow byte at edge k: `o_error`=1 and `o_busy`=0 from edge k+1; no write strobe.
- `i_start` at edge k: `o_busy`=1, and `o_done`/`o_error`/`o_byte_count`=0 from edge k+1.

## Test plan
1. **Normal load.** Reset, start, send 20 08 00 05, FF FF FF FF.
   - Expect 8 write pulses, addresses 0..7, data in that order.
   - Expect `o_done`=1 one cycle after the last pulse, `o_byte_count`=8, `o_busy`=0.
2. **Unaligned HALT.** Start, send AA FF FF FF FF 00 00 00.
   - Expect no `o_done`, 8 writes, still busy.
   - Then send FF FF FF FF: `o_done`, count=12.
3. **Overflow.** With MEMORY_DEPTH=16, start and send 17 bytes of 0x11.
   - Expect 16 writes at addresses 0..15.
   - The 17th byte gives no write, `o_error`=1, count=16.
4. **Restart.** Start, send 5 bytes, pulse `i_start`, send 1 byte.
   - Expect that byte written at address 0 and count=1.
   - Repeat with `i_start` and `i_rx_done` in the same cycle: expect no write.
5. **Ignored bytes.** Send bytes in IDLE and after DONE; expect no write pulses and outputs unchanged.
6. **Reset mid-load.** Assert `i_reset`=0 mid-load, including during an active write pulse.
   - Expect all outputs 0 next cycle and the block in IDLE.
   - Subsequent bytes are ignored until `i_start`.
